// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - FSM states and word extension for ram_window_deserializer
// DESER_SIGN_EXTEND_EN selects sign extension; otherwise words are zero-extended.
package deser_pkg;

  typedef enum logic [1:0] {IDLE, SKIP, COLLECT, HOLD} state_t;

  localparam int unsigned EXT_MAX = 64;

  function automatic logic [EXT_MAX-1:0] extend(input logic [EXT_MAX-1:0] word,
                                                input int unsigned in_w);
    logic [EXT_MAX-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < EXT_MAX; i++) begin
      if (i < in_w) begin
        res[i] = word[i];
      end
`ifdef DESER_SIGN_EXTEND_EN
      else begin
        res[i] = word[6'(in_w - 1)];
      end
`endif
    end
    return res;
  endfunction

endpackage

// File: rtl/deser_out_slot.sv
// rtl/deser_out_slot.sv - one-deep valid/ready register holding a completed window
module deser_out_slot #(
  parameter int N     = 9,
  parameter int OUT_W = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [N-1:0][OUT_W-1:0]   load_data,
  input  logic                      out_ready,
  output logic [N-1:0][OUT_W-1:0]   out_data,
  output logic                      out_valid,
  output logic                      slot_free
);

  assign slot_free = !out_valid || out_ready;

  // A load always wins over a simultaneous consume, so out_valid stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_window_deserializer.sv
// rtl/ram_window_deserializer.sv - collects N RAM words into one parallel window
// Word extension is selected by DESER_SIGN_EXTEND_EN (see deser_pkg).
module ram_window_deserializer #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 9,
  parameter int N     = 9,
  parameter int SKIP  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  output logic                      in_ready,
  output logic [N-1:0][OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      start_err
);
  import deser_pkg::*;

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  if (OUT_W < IN_W) begin : g_width_check
    $error("ram_window_deserializer: OUT_W must be >= IN_W");
  end

  state_t                    state, next_state;
  logic [IDX_W-1:0]          idx;
  logic [CNT_W-1:0]          cnt;
  logic [N-1:0][OUT_W-1:0]   coll_buf;
  logic [N-1:0][OUT_W-1:0]   window;
  logic [OUT_W-1:0]          ext_word;
  logic                      accept, last, load, slot_free, skip_done;

  assign ext_word  = OUT_W'(extend(64'(in_data), IN_W));
  assign accept    = in_ready && in_valid;
  assign last      = accept && (idx == IDX_W'(N - 1));
  assign skip_done = (cnt == CNT_W'(SKIP - 1));
  assign load      = slot_free && ((state == COLLECT && last) || state == HOLD);
  assign busy      = (state != IDLE);

  // The window handed to the slot must include the word accepted this very cycle.
  always_comb begin
    window = coll_buf;
    if (accept) window[idx] = ext_word;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    start_err  = 1'b0;
    unique case (state)
      IDLE:           if (start) next_state = (SKIP == 0) ? COLLECT : deser_pkg::SKIP;
      deser_pkg::SKIP: if (skip_done) next_state = COLLECT;
      COLLECT: begin
        in_ready = 1'b1;
        if (last) next_state = slot_free ? IDLE : HOLD;
      end
      HOLD:           if (slot_free) next_state = IDLE;
      default:        next_state = IDLE;
    endcase
    if (start && state != IDLE) start_err = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      coll_buf <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        idx <= '0;
        cnt <= '0;
      end
      if (state == deser_pkg::SKIP) cnt <= skip_done ? '0 : cnt + 1'b1;
      if (accept) begin
        coll_buf[idx] <= ext_word;
        idx           <= last ? '0 : idx + 1'b1;
      end
    end
  end

  deser_out_slot #(.N(N), .OUT_W(OUT_W)) u_out_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (window),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_ram_window_deserializer.sv
// tb/tb_ram_window_deserializer.sv - directed table-driven bench for ram_window_deserializer
module tb_ram_window_deserializer;
  localparam int IN_W  = 8;
  localparam int OUT_W = 9;
  localparam int N     = 9;
  localparam int SKIP  = 3;

  typedef logic [N-1:0][IN_W-1:0]  words_t;
  typedef logic [N-1:0][OUT_W-1:0] win_t;
  typedef struct {
    words_t w;
    win_t   e;
    bit     bubbles;
    int     err_at;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, out_valid, out_ready, busy, start_err;
  logic [IN_W-1:0] in_data;
  win_t out_data;
  int checks = 0;
  int fails  = 0;
  vec_t tbl[4];

  ram_window_deserializer #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N), .SKIP(SKIP)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input win_t act, input win_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic words_t ramp_w(input int base);
    words_t w;
    for (int k = 0; k < N; k++) w[k] = IN_W'(base + k);
    return w;
  endfunction

  function automatic win_t ramp_e(input int base);
    win_t e;
    for (int k = 0; k < N; k++) e[k] = OUT_W'(base + k);
    return e;
  endfunction

  // Called at a negedge; leaves start low at the following negedge (state SKIP).
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input words_t w, input bit bubbles, input int err_at,
                      input int nwords, input string tag);
    int k = 0;
    int cyc = 0;
    int idle_cnt = 0;
    bit seen = 1'b0;
    bit fired = 1'b0;
    bit chk_low = 1'b0;
    bit acc;
    while (k < nwords && cyc < 200) begin
      in_valid = bubbles ? ((cyc % 2) == 0) : 1'b1;
      in_data  = w[k];
      start    = (k == err_at) && !fired;
      #1;
      if (start) begin
        fired   = 1'b1;
        chk_low = 1'b1;
        check1({tag, "_start_err_hi"}, start_err, 1'b1);
      end else if (chk_low) begin
        chk_low = 1'b0;
        check1({tag, "_start_err_lo"}, start_err, 1'b0);
      end
      acc = in_valid && in_ready;
      if (!in_ready && !seen) idle_cnt++;
      if (acc) seen = 1'b1;
      @(posedge clk);
      if (acc) k++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (k < nwords) check_int({tag, "_timeout_words"}, k, nwords);
    if (!bubbles) check_int({tag, "_skip_cycles"}, idle_cnt, SKIP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0]  xw[N];
    logic [OUT_W-1:0] xe[N];

    xw = '{8'hFF, 8'h80, 8'h7F, 8'h00, 8'h01, 8'h55, 8'hAA, 8'hFE, 8'h02};
`ifdef DESER_SIGN_EXTEND_EN
    xe = '{9'h1FF, 9'h180, 9'h07F, 9'h000, 9'h001, 9'h055, 9'h1AA, 9'h1FE, 9'h002};
`else
    xe = '{9'h0FF, 9'h080, 9'h07F, 9'h000, 9'h001, 9'h055, 9'h0AA, 9'h0FE, 9'h002};
`endif
    tbl[0] = '{w: ramp_w(1),  e: ramp_e(1),  bubbles: 1'b0, err_at: -1};
    tbl[1] = '{w: '0,         e: '0,         bubbles: 1'b0, err_at: -1};
    for (int k = 0; k < N; k++) begin
      tbl[1].w[k] = xw[k];
      tbl[1].e[k] = xe[k];
    end
    tbl[2] = '{w: ramp_w(10), e: ramp_e(10), bubbles: 1'b1, err_at: -1};
    tbl[3] = '{w: ramp_w(40), e: ramp_e(40), bubbles: 1'b0, err_at: 4};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check_win("rst_out_data", out_data, '0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_start_err", start_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      start_pulse();
      feed(tbl[i].w, tbl[i].bubbles, tbl[i].err_at, N, $sformatf("vec%0d", i));
      check1($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      check_win($sformatf("vec%0d_out_data", i), out_data, tbl[i].e);
      check1($sformatf("vec%0d_busy_done", i), busy, 1'b0);
      @(negedge clk);
      check1($sformatf("vec%0d_drained", i), out_valid, 1'b0);
    end

    // Back-pressure: window B waits in HOLD until A is consumed.
    out_ready = 1'b0;
    start_pulse();
    feed(ramp_w(21), 1'b0, -1, N, "bp_a");
    check1("bp_a_valid", out_valid, 1'b1);
    check_win("bp_a_data", out_data, ramp_e(21));
    start_pulse();
    feed(ramp_w(31), 1'b0, -1, N, "bp_b");
    for (int c = 0; c < 2; c++) begin
      check1($sformatf("bp_hold%0d_busy", c), busy, 1'b1);
      check1($sformatf("bp_hold%0d_in_ready", c), in_ready, 1'b0);
      check1($sformatf("bp_hold%0d_valid", c), out_valid, 1'b1);
      check_win($sformatf("bp_hold%0d_data", c), out_data, ramp_e(21));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check1("bp_b_valid", out_valid, 1'b1);
    check_win("bp_b_data", out_data, ramp_e(31));
    check1("bp_b_idle", busy, 1'b0);
    @(negedge clk);
    check1("bp_b_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_b_drained", out_valid, 1'b0);

    // Reset in the middle of a frame while a window is still held.
    out_ready = 1'b0;
    start_pulse();
    feed(ramp_w(1), 1'b0, -1, N, "rs_c");
    check1("rs_c_valid", out_valid, 1'b1);
    start_pulse();
    feed(ramp_w(50), 1'b0, -1, 4, "rs_d");
    check1("rs_d_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check1("rs_out_valid", out_valid, 1'b0);
    check_win("rs_out_data", out_data, '0);
    check1("rs_busy", busy, 1'b0);
    check1("rs_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start_pulse();
    feed(ramp_w(60), 1'b0, -1, N, "rs_e");
    check1("rs_e_valid", out_valid, 1'b1);
    check_win("rs_e_data", out_data, ramp_e(60));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
